// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined operand-2 barrel shifter:
// shift-type encodings and the amount classification produced in stage 1.
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Class of the shift amount relative to the datapath width W
  typedef enum logic [1:0] {
    AMT_ZERO = 2'b00,
    AMT_LT   = 2'b01,
    AMT_EQ   = 2'b10,
    AMT_GT   = 2'b11
  } amt_cls_e;

endpackage

// File: rtl/shift_core.sv
// Purely combinational W-wide ARM shift/carry core. The amount arrives
// pre-classified (ZERO/LT/EQ/GT) with rot = amount mod W, and the immediate
// #0 special cases are already folded into the class or the RRX flag.
module shift_core
  import shifter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]         i_base,
  input  logic [1:0]           i_typ,
  input  amt_cls_e             i_cls,
  input  logic [$clog2(W)-1:0] i_rot,
  input  logic                 i_rrx,
  input  logic                 i_fc,
  output logic [W-1:0]         o_data,
  output logic                 o_co
);

  // One guard bit beside the operand collects the last bit shifted out
  logic [W:0]     w_lsl;
  logic [W:0]     w_lsr;
  logic [W:0]     w_asr;
  logic [2*W-1:0] w_ror;

  // Raw shifter arrays for the in-range (0 < n < W) cases
  always_comb begin
    w_lsl = {1'b0, i_base} << i_rot;
    w_lsr = {i_base, 1'b0} >> i_rot;
    w_asr = $signed({i_base, 1'b0}) >>> i_rot;
    w_ror = {i_base, i_base} >> i_rot;
  end

  // Select result and carry by shift type and amount class
  always_comb begin
    o_data = i_base;
    o_co   = i_fc;
    if (i_rrx) begin
      o_data = {i_fc, i_base[W-1:1]};
      o_co   = i_base[0];
    end else begin
      case (i_typ)
        SH_LSL: begin
          case (i_cls)
            AMT_ZERO: begin o_data = i_base;        o_co = i_fc;      end
            AMT_LT:   begin o_data = w_lsl[W-1:0];  o_co = w_lsl[W];  end
            AMT_EQ:   begin o_data = '0;            o_co = i_base[0]; end
            AMT_GT:   begin o_data = '0;            o_co = 1'b0;      end
            default:  begin o_data = i_base;        o_co = i_fc;      end
          endcase
        end
        SH_LSR: begin
          case (i_cls)
            AMT_ZERO: begin o_data = i_base;        o_co = i_fc;        end
            AMT_LT:   begin o_data = w_lsr[W:1];    o_co = w_lsr[0];    end
            AMT_EQ:   begin o_data = '0;            o_co = i_base[W-1]; end
            AMT_GT:   begin o_data = '0;            o_co = 1'b0;        end
            default:  begin o_data = i_base;        o_co = i_fc;        end
          endcase
        end
        SH_ASR: begin
          case (i_cls)
            AMT_ZERO: begin o_data = i_base;            o_co = i_fc;        end
            AMT_LT:   begin o_data = w_asr[W:1];        o_co = w_asr[0];    end
            AMT_EQ:   begin o_data = {W{i_base[W-1]}};  o_co = i_base[W-1]; end
            AMT_GT:   begin o_data = {W{i_base[W-1]}};  o_co = i_base[W-1]; end
            default:  begin o_data = i_base;            o_co = i_fc;        end
          endcase
        end
        SH_ROR: begin
          if (i_cls == AMT_ZERO) begin
            o_data = i_base;
            o_co   = i_fc;
          end else if (i_rot == '0) begin
            // Multiple of W: value unchanged, carry is the MSB
            o_data = i_base;
            o_co   = i_base[W-1];
          end else begin
            o_data = w_ror[W-1:0];
            o_co   = w_ror[W-1];
          end
        end
        default: begin
          o_data = i_base;
          o_co   = i_fc;
        end
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Two-stage pipelined ARM operand-2 barrel shifter with valid/ready handshake.
// Stage 1 registers the request and classifies the amount at full AMT_W width;
// stage 2 registers the shift_core result together with the sideband tag.
// Build option SHIFTER_SKID_EN: stage 2 becomes a 2-entry output skid buffer
// and in_ready is registered (no combinational out_ready -> in_ready path).
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int W     = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_base,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_rg,
  input  logic [1:0]       in_typ,
  input  logic             in_fc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_co,
  output logic [TAG_W-1:0] out_tag
);

  localparam int               RW    = $clog2(W);
  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(W);

  // Stage 1 registers
  logic             r_s1_valid;
  logic [W-1:0]     r_s1_base;
  logic [1:0]       r_s1_typ;
  amt_cls_e         r_s1_cls;
  logic [RW-1:0]    r_s1_rot;
  logic             r_s1_rrx;
  logic             r_s1_fc;
  logic [TAG_W-1:0] r_s1_tag;

  // Output stage registers (head entry in the skid build)
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic             r_out_co;
  logic [TAG_W-1:0] r_out_tag;

  amt_cls_e         w_cls;
  logic             w_rrx;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_s1_adv;
  logic [W-1:0]     w_core_data;
  logic             w_core_co;

  // Classify the amount; immediate #0 is folded into ZERO / EQ / RRX here
  always_comb begin
    w_cls = AMT_ZERO;
    w_rrx = 1'b0;
    if (in_amount == '0) begin
      if (in_rg) begin
        w_cls = AMT_ZERO;
      end else begin
        case (in_typ)
          SH_LSR:  w_cls = AMT_EQ;
          SH_ASR:  w_cls = AMT_EQ;
          SH_ROR:  w_rrx = 1'b1;
          default: w_cls = AMT_ZERO;
        endcase
      end
    end else if (in_amount < W_AMT) begin
      w_cls = AMT_LT;
    end else if (in_amount == W_AMT) begin
      w_cls = AMT_EQ;
    end else begin
      w_cls = AMT_GT;
    end
  end

  assign w_in_fire = in_valid && in_ready;

  // Stage 1: capture accepted request, empty when it moves on with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_base  <= '0;
      r_s1_typ   <= 2'b00;
      r_s1_cls   <= AMT_ZERO;
      r_s1_rot   <= '0;
      r_s1_rrx   <= 1'b0;
      r_s1_fc    <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_base  <= in_base;
      r_s1_typ   <= in_typ;
      r_s1_cls   <= w_cls;
      r_s1_rot   <= in_amount[RW-1:0];
      r_s1_rrx   <= w_rrx;
      r_s1_fc    <= in_fc;
      r_s1_tag   <= in_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  shift_core #(
    .W (W)
  ) u_core (
    .i_base (r_s1_base),
    .i_typ  (r_s1_typ),
    .i_cls  (r_s1_cls),
    .i_rot  (r_s1_rot),
    .i_rrx  (r_s1_rrx),
    .i_fc   (r_s1_fc),
    .o_data (w_core_data),
    .o_co   (w_core_co)
  );

`ifdef SHIFTER_SKID_EN

  logic [1:0]       r_cnt;
  logic             r_in_ready;
  logic [W-1:0]     r_skid_data;
  logic             r_skid_co;
  logic [TAG_W-1:0] r_skid_tag;
  logic [1:0]       w_cnt_nxt;
  logic             w_s1_valid_nxt;
  logic             w_ready_nxt;

  assign w_out_fire = r_out_valid && out_ready;
  assign w_s1_adv   = r_s1_valid && ((r_cnt != 2'd2) || w_out_fire);
  assign in_ready   = r_in_ready;

  // Next occupancy; accept next cycle only if stage 1 is then sure to drain
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_s1_adv && !w_out_fire) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!w_s1_adv && w_out_fire) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
    if (w_in_fire) begin
      w_s1_valid_nxt = 1'b1;
    end else if (w_s1_adv) begin
      w_s1_valid_nxt = 1'b0;
    end else begin
      w_s1_valid_nxt = r_s1_valid;
    end
    w_ready_nxt = ({2'b00, w_s1_valid_nxt} + {1'b0, w_cnt_nxt}) <= 3'd2;
  end

  // Two-entry output buffer: head drives the outputs, skid holds the overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_co    <= 1'b0;
      r_out_tag   <= '0;
      r_skid_data <= '0;
      r_skid_co   <= 1'b0;
      r_skid_tag  <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_ready_nxt;
      r_out_valid <= (w_cnt_nxt != 2'd0);
      case (r_cnt)
        2'd0: begin
          if (w_s1_adv) begin
            r_out_data <= w_core_data;
            r_out_co   <= w_core_co;
            r_out_tag  <= r_s1_tag;
          end
        end
        2'd1: begin
          if (w_s1_adv && w_out_fire) begin
            r_out_data <= w_core_data;
            r_out_co   <= w_core_co;
            r_out_tag  <= r_s1_tag;
          end else if (w_s1_adv) begin
            r_skid_data <= w_core_data;
            r_skid_co   <= w_core_co;
            r_skid_tag  <= r_s1_tag;
          end
        end
        2'd2: begin
          if (w_out_fire) begin
            r_out_data <= r_skid_data;
            r_out_co   <= r_skid_co;
            r_out_tag  <= r_skid_tag;
            if (w_s1_adv) begin
              r_skid_data <= w_core_data;
              r_skid_co   <= w_core_co;
              r_skid_tag  <= r_s1_tag;
            end
          end
        end
        default: begin
          r_out_data <= r_out_data;
        end
      endcase
    end
  end

`else

  assign w_out_fire = r_out_valid && out_ready;
  assign w_s1_adv   = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s1_adv;

  // Stage 2: load the core result when stage 1 advances, else drain on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_co    <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_core_data;
      r_out_co    <= w_core_co;
      r_out_tag   <= r_s1_tag;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_co    = r_out_co;
  assign out_tag   = r_out_tag;

endmodule
